// File: rtl/uart_send.sv
// 8N1 UART transmitter, LSB first, with busy/done handshake for back-to-back streaming.
// Define UART_SEND_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_send #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_en,
  input  logic [7:0] uart_din,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BIT_LAST = 16'(BPS_CNT - 1);

`ifdef UART_SEND_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bit_end;
`ifdef UART_SEND_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign bit_end = (clk_cnt_q == BIT_LAST);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
`ifdef UART_SEND_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state_q != IDLE) begin
      clk_cnt_d = bit_end ? 16'd0 : clk_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        clk_cnt_d = 16'd0;
        if (uart_en) begin
          state_d   = START;
          shift_d   = uart_din;
          bit_cnt_d = 3'd0;
`ifdef UART_SEND_PARITY_EN
          parity_d  = ^uart_din;
`endif
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_SEND_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_SEND_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next state so the pin is a clean register output.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_SEND_PARITY_EN
      PARITY:  txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_SEND_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_SEND_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send at BPS_CNT=10: per-cycle frame-position model plus literal line patterns.
// Builds with or without UART_SEND_PARITY_EN.
module tb_uart_send;

  localparam int BPS = 10;
`ifdef UART_SEND_PARITY_EN
  localparam int NBITS = 11;
  // line order bit0=start ... bit9=parity, bit10=stop
  localparam logic [10:0] L_A5 = 11'b1_0_10100101_0;
  localparam logic [10:0] L_00 = 11'b1_0_00000000_0;
  localparam logic [10:0] L_FF = 11'b1_0_11111111_0;
  localparam logic [10:0] L_C3 = 11'b1_0_11000011_0;
  localparam logic [10:0] L_96 = 11'b1_0_10010110_0;
  localparam logic [10:0] L_07 = 11'b1_1_00000111_0;
  localparam logic [10:0] L_03 = 11'b1_0_00000011_0;
`else
  localparam int NBITS = 10;
  localparam logic [10:0] L_A5 = 11'b0_1_10100101_0;
  localparam logic [10:0] L_00 = 11'b0_1_00000000_0;
  localparam logic [10:0] L_FF = 11'b0_1_11111111_0;
  localparam logic [10:0] L_C3 = 11'b0_1_11000011_0;
  localparam logic [10:0] L_96 = 11'b0_1_10010110_0;
`endif
  localparam int FRAME = NBITS * BPS;
  localparam int TR    = 240;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_en   = 1'b0;
  logic [7:0] uart_din  = 8'h00;
  logic       uart_txd, tx_busy, tx_done;

  always #5 sys_clk = ~sys_clk;

  uart_send #(.CLK_FREQ(1_000_000), .UART_BPS(100_000)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .uart_en  (uart_en),
    .uart_din (uart_din),
    .uart_txd (uart_txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Model: position within the current frame, counted in cycles from the first start-bit cycle.
  logic       m_active;
  int         m_pos;
  logic [7:0] m_byte;
  logic       m_done;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_active <= 1'b0;
      m_pos    <= 0;
      m_byte   <= 8'h00;
      m_done   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (m_pos == FRAME - 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_pos <= m_pos + 1;
        end
      end else if (uart_en) begin
        m_active <= 1'b1;
        m_pos    <= 0;
        m_byte   <= uart_din;
      end
    end
  end

  function automatic logic exp_txd();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / BPS;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
`ifdef UART_SEND_PARITY_EN
    if (k == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(negedge sys_clk);
      if (check_en) begin
        chk("cyc_txd",  uart_txd, exp_txd());
        chk("cyc_busy", tx_busy,  m_active);
        chk("cyc_done", tx_done,  m_done);
      end
    end
  end

  logic txd_tr [TR];
  logic busy_tr[TR];
  logic done_tr[TR];

  task automatic store(input int i);
    txd_tr[i]  = uart_txd;
    busy_tr[i] = tx_busy;
    done_tr[i] = tx_done;
  endtask

  // Request a byte; returns after the acceptance edge.
  task automatic request(input logic [7:0] b, input bit pulse);
    @(posedge sys_clk); #2;
    uart_en  = 1'b1;
    uart_din = b;
    @(posedge sys_clk); #2;
    if (pulse) uart_en = 1'b0;
  endtask

  // Wait for the start bit (bounded) and record it as trace sample 0.
  task automatic wait_fall(input string name);
    int n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      n++;
      if (uart_txd == 1'b0) break;
    end
    chk({name, "_fall"}, uart_txd, 1'b0);
    chk({name, "_latency"}, n, 1);
    store(0);
  endtask

  task automatic collect(input int n, input int chg_at, input logic [7:0] chg_din, input int off_at);
    for (int i = 1; i < n; i++) begin
      @(negedge sys_clk);
      store(i);
      if (i == chg_at) begin
        uart_en  = 1'b1;
        uart_din = chg_din;
      end
      if (i == off_at) uart_en = 1'b0;
    end
  endtask

  task automatic check_frame(input string name, input int base, input logic [10:0] lit, input bit solo);
    int d = -1;
    int nb = 0;
    for (int k = 0; k < NBITS; k++) begin
      chk($sformatf("%s_bit%0d_first", name, k), txd_tr[base + k*BPS],         lit[k]);
      chk($sformatf("%s_bit%0d_mid",   name, k), txd_tr[base + k*BPS + 5],     lit[k]);
      chk($sformatf("%s_bit%0d_last",  name, k), txd_tr[base + k*BPS + BPS-1], lit[k]);
    end
    for (int i = base; i < base + FRAME + 5 && i < TR; i++) begin
      if (done_tr[i] && d < 0) d = i;
      if (busy_tr[i]) nb++;
    end
    chk({name, "_done_at"}, d - base, FRAME);
    if (solo) chk({name, "_busy_len"}, nb, FRAME);
  endtask

  initial begin
    int cnt;
    // reset values
    repeat (3) @(negedge sys_clk);
    chk("rst_txd",  uart_txd, 1'b1);
    chk("rst_busy", tx_busy,  1'b0);
    chk("rst_done", tx_done,  1'b0);
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b1;
    check_en  = 1'b1;
    repeat (50) @(posedge sys_clk);

    // single frame 0xA5
    request(8'hA5, 1'b1);
    wait_fall("a5");
    collect(FRAME + 10, -1, 8'h00, -1);
    check_frame("a5", 0, L_A5, 1'b1);
    $display("frame a5 checked");

    // uart_en held: 0x00 then 0xFF accepted in the tx_done cycle
    repeat (5) @(posedge sys_clk);
    request(8'h00, 1'b0);
    wait_fall("b2b");
    collect(2*FRAME + 10, 5, 8'hFF, FRAME + 50);
    check_frame("b2b0", 0, L_00, 1'b0);
    chk("b2b_gap_high",  txd_tr[FRAME],     1'b1);
    chk("b2b_gap_done",  done_tr[FRAME],    1'b1);
    chk("b2b_gap_busy",  busy_tr[FRAME],    1'b0);
    chk("b2b_2nd_start", txd_tr[FRAME + 1], 1'b0);
    check_frame("b2b1", FRAME + 1, L_FF, 1'b0);
    $display("frames 00/ff back-to-back checked");

    // mid-frame request and data change are ignored
    repeat (5) @(posedge sys_clk);
    request(8'hC3, 1'b1);
    wait_fall("c3");
    collect(FRAME + 10, 35, 8'h3C, 36);
    check_frame("c3", 0, L_C3, 1'b1);
    cnt = 0;
    for (int i = FRAME; i < FRAME + 10; i++) if (!txd_tr[i]) cnt++;
    chk("c3_no_extra", cnt, 0);
    $display("frame c3 with mid-frame request checked");

    // async reset at cycle 47 (data bit 3 of 0xA5 is low there)
    repeat (5) @(posedge sys_clk);
    request(8'hA5, 1'b1);
    wait_fall("abort");
    collect(47, -1, 8'h00, -1);
    @(negedge sys_clk);
    chk("abort_pre_txd", uart_txd, 1'b0);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("abort_txd",  uart_txd, 1'b1);
    chk("abort_busy", tx_busy,  1'b0);
    chk("abort_done", tx_done,  1'b0);
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      @(negedge sys_clk);
      if (tx_done) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    request(8'h96, 1'b1);
    wait_fall("96");
    collect(FRAME + 10, -1, 8'h00, -1);
    check_frame("96", 0, L_96, 1'b1);
    $display("abort and recovery frame 96 checked");

`ifdef UART_SEND_PARITY_EN
    repeat (5) @(posedge sys_clk);
    request(8'h07, 1'b1);
    wait_fall("p07");
    collect(FRAME + 10, -1, 8'h00, -1);
    check_frame("p07", 0, L_07, 1'b1);
    chk("p07_parity", txd_tr[9*BPS + 5], 1'b1);
    $display("parity frame 07 checked");
    repeat (5) @(posedge sys_clk);
    request(8'h03, 1'b1);
    wait_fall("p03");
    collect(FRAME + 10, -1, 8'h00, -1);
    check_frame("p03", 0, L_03, 1'b1);
    chk("p03_parity", txd_tr[9*BPS + 5], 1'b0);
    $display("parity frame 03 checked");
`endif

    repeat (5) @(posedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_send.md
Name: uart_send

Overview:
- 8N1 UART transmitter. It serialises one byte per request onto uart_txd, LSB first.
- Pairs with the existing uart_recv block: same CLK_FREQ/UART_BPS parameterisation and the same bit-period counting.
- Sits between the application logic (temperature/cipher datapath) and the board TX pin.
- Provides a busy/done handshake so that upstream logic can stream bytes back-to-back.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- UART_BPS, 9600, baud rate.
- BPS_CNT (localparam), CLK_FREQ/UART_BPS, system cycles per bit. Legal range is 2..65535; the bit counter is 16 bits wide.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- uart_en  in  1  send request, level-sampled; a request is accepted only in IDLE.
- uart_din  in  8  byte to send; sampled only in the acceptance cycle.
- uart_txd  out  1  serial line, registered output, idle high.
- tx_busy  out  1  high from the cycle after acceptance until the frame completes.
- tx_done  out  1  single-cycle pulse at the end of the stop bit.

Behaviour:
- Reset values: uart_txd=1, tx_busy=0, tx_done=0. Internal state: IDLE, clk_cnt=0, bit_cnt=0, shift register=0.
- Reset asserted mid-frame aborts immediately and asynchronously: uart_txd=1, tx_busy=0. No tx_done is produced for the aborted frame.
- States and transitions:
  - IDLE -> START when uart_en=1. In that cycle, latch uart_din into the shift register.
  - START -> DATA after BPS_CNT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> IDLE after BPS_CNT cycles.
- Bit timing:
  - clk_cnt runs 0..BPS_CNT-1 in every non-IDLE state.
  - A bit boundary occurs when clk_cnt==BPS_CNT-1; clk_cnt then wraps to 0.
  - clk_cnt is held at 0 in IDLE.
- Line values per state:
  - START drives 0.
  - DATA drives the shift-register LSB; the register shifts right at each bit boundary. bit_cnt counts 0..7.
  - STOP drives 1.
- Latency:
  - uart_txd goes low, and tx_busy goes high, on the first clock edge after the acceptance edge (one cycle).
  - Each bit lasts exactly BPS_CNT cycles.
  - The frame is exactly 10*BPS_CNT cycles from the first low cycle to the end of the stop bit.
- tx_done:
  - Pulses for 1 cycle on the same edge that STOP -> IDLE is taken.
  - tx_busy falls on that same edge.
- Back-to-back frames:
  - If uart_en=1 in the first IDLE cycle (the cycle where tx_done is high), the next frame is accepted immediately.
  - The next start bit therefore follows the stop bit with 1 idle-high cycle. Minimum frame spacing is 10*BPS_CNT+1 cycles.
- Requests while busy:
  - uart_en is ignored while tx_busy=1; no queueing.
  - Changes on uart_din during a frame do not affect the frame in flight.
- uart_en held high continuously produces continuous frames at minimum spacing, each carrying the uart_din value present in its acceptance cycle.

Optional Feature:
- Macro: UART_SEND_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting BPS_CNT cycles.
  - It drives even parity, i.e. the XOR of the 8 latched data bits.
  - The frame becomes 11*BPS_CNT cycles; minimum spacing becomes 11*BPS_CNT+1.
- Undefined: the PARITY state and parity logic are absent, and the frame is 8N1 as above.

Test Plan (CLK_FREQ=1_000_000, UART_BPS=100_000, BPS_CNT=10):
- Reset, then idle for 50 cycles -> uart_txd=1, tx_busy=0, tx_done=0 throughout.
- uart_en pulse for 1 cycle with uart_din=8'hA5 -> expected response:
  - txd low 1 cycle later, for 10 cycles.
  - Then bits 1,0,1,0,0,1,0,1, each 10 cycles.
  - Then high for 10 cycles.
  - tx_done pulses exactly 100 cycles after txd first falls; tx_busy is high for exactly 100 cycles.
- uart_en held high with uart_din=8'h00, then 8'hFF applied after the first acceptance -> expected response:
  - First frame sends 0x00.
  - Second frame is accepted in the tx_done cycle and sends 0xFF.
  - Exactly 1 high cycle separates the stop bit from the second start bit.
- uart_en pulsed and uart_din=8'h3C changed at cycle 35 of a frame carrying 8'hC3 -> the frame still carries 0xC3; the mid-frame request produces no extra frame.
- sys_rst_n asserted at cycle 47 of a frame -> uart_txd=1 and tx_busy=0 asynchronously, with no tx_done. The next request after release sends a full, correct frame.
- With UART_SEND_PARITY_EN defined, send 8'h07 -> expected response:
  - Parity bit = 1.
  - Frame is 110 cycles; tx_done pulses at cycle 110.
  - Sending 8'h03 gives parity bit = 0.
